// File: rtl/maxpool_relu1_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maxpool_relu1_pkg : shared conv1 geometry, sample type and signed max helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package maxpool_relu1_pkg;

   localparam int CONV_BIT   = 12;
   localparam int WIDTH      = 24;
   localparam int HEIGHT     = 24;
   localparam int HALF_WIDTH = WIDTH / 2;

   localparam int COL_W  = $clog2(WIDTH);
   localparam int ROW_W  = $clog2(HEIGHT);
   localparam int ADDR_W = $clog2(HALF_WIDTH);

   typedef logic signed [CONV_BIT-1:0] sample_t;

   function automatic sample_t smax(input sample_t a, input sample_t b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_relu1_pool_linebuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_linebuf : per-channel row buffer of pair maxima, async read
// Revision: 1.0
// ---------------------------------------------------------------------------
module pool_linebuf
   import maxpool_relu1_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  sample_t           wdata,
   output sample_t           rdata
);

   // Always written on an even row before being read, so no reset is needed.
   sample_t mem_q [HALF_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule
`default_nettype wire

// File: rtl/maxpool_relu1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// maxpool_relu1 : 2x2 stride-2 max pooling + ReLU on three conv1 channels
// Revision: 1.0
// ---------------------------------------------------------------------------
module maxpool_relu1
   import maxpool_relu1_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid_out_conv,
   input  logic [CONV_BIT-1:0] conv_out_1,
   input  logic [CONV_BIT-1:0] conv_out_2,
   input  logic [CONV_BIT-1:0] conv_out_3,
   output logic [CONV_BIT-1:0] max_value_1,
   output logic [CONV_BIT-1:0] max_value_2,
   output logic [CONV_BIT-1:0] max_value_3,
   output logic                valid_out_relu
);

   localparam int                NCH      = 3;
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
   localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
   localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              valid_q, valid_d;
   logic              lb_we;
   logic              fire;
   logic [ADDR_W-1:0] lb_addr;

   sample_t sample   [NCH];
   sample_t hold_q   [NCH];
   sample_t hold_d   [NCH];
   sample_t max_q    [NCH];
   sample_t max_d    [NCH];
   sample_t pair_max [NCH];
   sample_t quad_max [NCH];
   sample_t lb_rdata [NCH];

   assign sample[0] = sample_t'(conv_out_1);
   assign sample[1] = sample_t'(conv_out_2);
   assign sample[2] = sample_t'(conv_out_3);

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_out_conv) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;
         end else begin
            col_d = col_q + COL_ONE;
         end
      end
   end

   // Even rows deposit pair maxima; odd rows fold them in and emit.
   always_comb begin
      lb_we   = valid_out_conv & col_q[0] & ~row_q[0];
      fire    = valid_out_conv & col_q[0] &  row_q[0];
      lb_addr = ADDR_W'(col_q >> 1);
      valid_d = fire;
      for (int ch = 0; ch < NCH; ch++) begin
         hold_d[ch]   = (valid_out_conv && !col_q[0]) ? sample[ch] : hold_q[ch];
         pair_max[ch] = smax(hold_q[ch], sample[ch]);
         quad_max[ch] = smax(pair_max[ch], lb_rdata[ch]);
         max_d[ch]    = max_q[ch];
         if (fire) begin
            max_d[ch] = quad_max[ch][CONV_BIT-1] ? '0 : quad_max[ch];
         end
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      pool_linebuf u_linebuf (
         .clk   (clk),
         .we    (lb_we),
         .addr  (lb_addr),
         .wdata (pair_max[gi]),
         .rdata (lb_rdata[gi])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         for (int ch = 0; ch < NCH; ch++) begin
            hold_q[ch] <= '0;
            max_q[ch]  <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         for (int ch = 0; ch < NCH; ch++) begin
            hold_q[ch] <= hold_d[ch];
            max_q[ch]  <= max_d[ch];
         end
      end
   end

   assign max_value_1    = max_q[0];
   assign max_value_2    = max_q[1];
   assign max_value_3    = max_q[2];
   assign valid_out_relu = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_relu1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_maxpool_relu1 : self-checking bench, frame-array reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_maxpool_relu1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_out_conv = 1'b0;
   logic [11:0] conv_out_1 = '0, conv_out_2 = '0, conv_out_3 = '0;
   logic [11:0] max_value_1, max_value_2, max_value_3;
   logic        valid_out_relu;

   maxpool_relu1 dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_out_conv (valid_out_conv),
      .conv_out_1     (conv_out_1),
      .conv_out_2     (conv_out_2),
      .conv_out_3     (conv_out_3),
      .max_value_1    (max_value_1),
      .max_value_2    (max_value_2),
      .max_value_3    (max_value_3),
      .valid_out_relu (valid_out_relu)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: whole frame stored, pooled value taken over the 2x2 block.
   int fr [3][24][24];
   int mr = 0, mc = 0;
   bit ev = 0;
   int e0 = 0, e1 = 0, e2 = 0;

   int dut_cnt = 0;
   int first1 = -1;
   int last1 = -1;

   typedef struct {
      int a; int b; int c; int d; int exp;
   } vec_t;
   vec_t vt [8];

   function automatic int sx(input int a);
      logic signed [11:0] t;
      t = a[11:0];
      return int'(t);
   endfunction

   function automatic int pool(input int ch, input int r, input int c);
      int m;
      m = fr[ch][r-1][c-1];
      for (int dr = 0; dr < 2; dr++)
         for (int dc = 0; dc < 2; dc++)
            if (fr[ch][r-dr][c-dc] > m) m = fr[ch][r-dr][c-dc];
      return (m > 0) ? m : 0;
   endfunction

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic step(input bit v, input int a, input int b, input int d);
      valid_out_conv = v;
      conv_out_1 = 12'(a);
      conv_out_2 = 12'(b);
      conv_out_3 = 12'(d);
      ev = 0;
      if (v) begin
         fr[0][mr][mc] = sx(a);
         fr[1][mr][mc] = sx(b);
         fr[2][mr][mc] = sx(d);
         if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            ev = 1;
            e0 = pool(0, mr, mc);
            e1 = pool(1, mr, mc);
            e2 = pool(2, mr, mc);
         end
         if (mc == 23) begin
            mc = 0;
            mr = (mr == 23) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end
      @(negedge clk);
      checks++;
      if ({valid_out_relu, max_value_1, max_value_2, max_value_3} !==
          {ev, 12'(e0), 12'(e1), 12'(e2)}) begin
         errors++;
         $display("FAIL cycle t=%0t: got v=%0b %0d %0d %0d, expected v=%0b %0d %0d %0d",
                  $time, valid_out_relu, max_value_1, max_value_2, max_value_3,
                  ev, e0, e1, e2);
      end
      if (valid_out_relu === 1'b1) begin
         dut_cnt++;
         if (first1 < 0) first1 = int'(max_value_1);
         last1 = int'(max_value_1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid_out_conv = 1'b0;
      @(negedge clk);
      checks++;
      if ({valid_out_relu, max_value_1, max_value_2, max_value_3} !== 37'd0) begin
         errors++;
         $display("FAIL reset: got v=%0b %0d %0d %0d, expected all 0",
                  valid_out_relu, max_value_1, max_value_2, max_value_3);
      end
      rst_n = 1'b1;
      mr = 0; mc = 0; ev = 0;
      e0 = 0; e1 = 0; e2 = 0;
   endtask

   task automatic send(input int a, input int b, input int d, input int maxgap);
      int g;
      g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      repeat (g) step(0, int'($urandom), int'($urandom), int'($urandom));
      step(1, a, b, d);
   endtask

   // mode 0: zeros; 1: ramp / -5 / random; 2: all random
   task automatic frame(input int mode, input int maxgap, input int nsamp);
      int r, c;
      for (int k = 0; k < nsamp; k++) begin
         r = k / 24;
         c = k % 24;
         case (mode)
            0:       send(0, 0, 0, maxgap);
            1:       send(r * 24 + c, -5, int'($urandom), maxgap);
            default: send(int'($urandom), int'($urandom), int'($urandom), maxgap);
         endcase
      end
   endtask

   task automatic clear_counts();
      dut_cnt = 0; first1 = -1; last1 = -1;
   endtask

   initial begin
      vt[0] = '{0, 0, 0, 0, 0};
      vt[1] = '{-1, -300, -300, -300, 0};
      vt[2] = '{-7, 3, -2, 2047, 2047};
      vt[3] = '{5, 9, -3, 1, 9};
      vt[4] = '{-2048, -2048, -2048, -2048, 0};
      vt[5] = '{100, 100, 100, 100, 100};
      vt[6] = '{-1, 1, 0, 0, 1};
      vt[7] = '{2047, -2048, 0, 0, 2047};

      @(negedge clk);
      do_reset();

      // Single 2x2 blocks on channel 3
      for (int i = 0; i < 8; i++) begin
         do_reset();
         step(1, 0, 0, vt[i].a);
         step(1, 0, 0, vt[i].b);
         for (int k = 2; k < 24; k++) step(1, 0, 0, 0);
         step(1, 0, 0, vt[i].c);
         step(1, 0, 0, vt[i].d);
         check_int($sformatf("vec%0d", i), sx(int'(max_value_3)), vt[i].exp);
      end

      do_reset();
      clear_counts();
      frame(0, 0, 576);
      check_int("zero_count", dut_cnt, 144);

      clear_counts();
      frame(1, 0, 576);
      check_int("ramp_count", dut_cnt, 144);
      check_int("ramp_first", first1, 25);
      check_int("ramp_last", last1, 575);

      clear_counts();
      frame(1, 3, 576);
      check_int("gap_count", dut_cnt, 144);
      check_int("gap_first", first1, 25);
      check_int("gap_last", last1, 575);

      frame(1, 0, 300);
      do_reset();
      clear_counts();
      frame(1, 0, 576);
      check_int("rst_count", dut_cnt, 144);
      check_int("rst_first", first1, 25);
      check_int("rst_last", last1, 575);

      clear_counts();
      frame(2, 0, 576);
      frame(2, 0, 576);
      check_int("b2b_count", dut_cnt, 288);

      repeat (3) step(0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
